// File: rtl/td4_core_param.sv
// TD4-compatible single-cycle core with parametrised widths,
// fetch-valid handshake and halt/single-step debug control.
module td4_core_param #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 4,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+3:0] instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] in_port,
    input  logic              halt_req,
    input  logic              step,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] out_port,
    output logic              cf,
    output logic              halted,
    output logic              retired
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_A,
        SRC_B,
        SRC_IN
    } src_t;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_A,
        DST_B,
        DST_OUT
    } dst_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    src_t              src_sel;
    dst_t              dst_sel;
    logic              is_jmp;
    logic              is_jnc;
    logic              is_nop;

    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic [ADDR_W-1:0] pc_next;
    logic              exe;

    assign opcode = instr[DATA_W+3:DATA_W];
    assign imm    = instr[DATA_W-1:0];

    always_comb begin
        src_sel = SRC_ZERO;
        dst_sel = DST_NONE;
        is_jmp  = 1'b0;
        is_jnc  = 1'b0;
        is_nop  = 1'b0;
        unique case (opcode)
            4'b0000: begin src_sel = SRC_A;    dst_sel = DST_A;   end
            4'b0001: begin src_sel = SRC_B;    dst_sel = DST_A;   end
            4'b0010: begin src_sel = SRC_IN;   dst_sel = DST_A;   end
            4'b0011: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
            4'b0100: begin src_sel = SRC_A;    dst_sel = DST_B;   end
            4'b0101: begin src_sel = SRC_B;    dst_sel = DST_B;   end
            4'b0110: begin src_sel = SRC_IN;   dst_sel = DST_B;   end
            4'b0111: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
            4'b1001: begin src_sel = SRC_B;    dst_sel = DST_OUT; end
            4'b1011: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
            4'b1110: is_jnc = 1'b1;
            4'b1111: is_jmp = 1'b1;
            default: is_nop = 1'b1;
        endcase
    end

    always_comb begin
        src_val = '0;
        unique case (src_sel)
            SRC_A:   src_val = reg_a;
            SRC_B:   src_val = reg_b;
            SRC_IN:  src_val = in_port;
            default: src_val = '0;
        endcase
    end

    // Jumps select a zero source, so their carry is naturally 0.
    assign {carry, sum} = {1'b0, src_val} + {1'b0, imm};

    always_comb begin
        pc_next = pc + PC_ONE;
        if (is_jmp || (is_jnc && !cf)) begin
            pc_next = ADDR_W'(imm);
        end
    end

    assign exe = instr_valid &&
                 (((state == RUN) && !halt_req) ||
                  ((state == HALTED) && step));

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (halt_req) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req && !step) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_HALTED ? HALTED : RUN;
            retired <= 1'b0;
        end else begin
            state   <= state_next;
            retired <= exe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            cf       <= 1'b0;
        end else if (exe) begin
            if (dst_sel == DST_A) begin
                reg_a <= sum;
            end
            if (dst_sel == DST_B) begin
                reg_b <= sum;
            end
            if (dst_sel == DST_OUT) begin
                out_port <= sum;
            end
            pc <= pc_next;
            if (!is_nop) begin
                cf <= carry;
            end
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param: hand tables, a counter-loop program and
// random stimulus against an arithmetic reference model (4- and 8-bit).
module tb_td4_core_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  instr4 = '0;
    logic        valid4 = 1'b0;
    logic [3:0]  in4 = '0;
    logic        hreq4 = 1'b0;
    logic        step4 = 1'b0;
    logic [3:0]  pc4;
    logic [3:0]  out4;
    logic        cf4;
    logic        h4;
    logic        ret4;

    logic [11:0] instr8 = '0;
    logic        valid8 = 1'b0;
    logic [7:0]  in8 = '0;
    logic        hreq8 = 1'b1;
    logic        step8 = 1'b0;
    logic [7:0]  pc8;
    logic [7:0]  out8;
    logic        cf8;
    logic        h8;
    logic        ret8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    td4_core_param #(.DATA_W(4), .ADDR_W(4), .RESET_HALTED(1'b0)) dut4 (
        .clk(clk), .rst(rst), .instr(instr4), .instr_valid(valid4),
        .in_port(in4), .halt_req(hreq4), .step(step4), .pc(pc4),
        .out_port(out4), .cf(cf4), .halted(h4), .retired(ret4)
    );

    td4_core_param #(.DATA_W(8), .ADDR_W(8), .RESET_HALTED(1'b1)) dut8 (
        .clk(clk), .rst(rst), .instr(instr8), .instr_valid(valid8),
        .in_port(in8), .halt_req(hreq8), .step(step8), .pc(pc8),
        .out_port(out8), .cf(cf8), .halted(h8), .retired(ret8)
    );

    typedef struct {
        int a;
        int b;
        int o;
        int pc;
        bit cf;
        bit h;
        bit ret;
    } ms_t;

    ms_t m4;
    ms_t m8;

    function automatic ms_t mreset(bit h);
        ms_t n;
        n.a = 0; n.b = 0; n.o = 0; n.pc = 0;
        n.cf = 0; n.h = h; n.ret = 0;
        return n;
    endfunction

    // Architectural step from the ISA table using plain integer arithmetic.
    function automatic ms_t mstep(ms_t s, int dw, int aw, int op, int imm,
                                  int inp, bit v, bit hr, bit st);
        ms_t n;
        int m;
        int src;
        int dst;
        bit exe;
        n = s;
        m = 1 << dw;
        exe = v && (s.h ? st : !hr);
        n.ret = exe;
        n.h = s.h ? (hr || st) : hr;
        if (exe) begin
            n.pc = (s.pc + 1) % (1 << aw);
            src = 0;
            dst = 0;
            case (op)
                0:  begin src = s.a; dst = 1; end
                1:  begin src = s.b; dst = 1; end
                2:  begin src = inp; dst = 1; end
                3:  begin src = 0;   dst = 1; end
                4:  begin src = s.a; dst = 2; end
                5:  begin src = s.b; dst = 2; end
                6:  begin src = inp; dst = 2; end
                7:  begin src = 0;   dst = 2; end
                9:  begin src = s.b; dst = 3; end
                11: begin src = 0;   dst = 3; end
                14: begin if (!s.cf) n.pc = imm; n.cf = 0; end
                15: begin n.pc = imm; n.cf = 0; end
                default: ;
            endcase
            if (dst != 0) begin
                n.cf = (src + imm) >= m;
                case (dst)
                    1: n.a = (src + imm) % m;
                    2: n.b = (src + imm) % m;
                    default: n.o = (src + imm) % m;
                endcase
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, integer got, integer exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_models(string tag);
        chk({tag, ".m4.pc"}, pc4, m4.pc);
        chk({tag, ".m4.out"}, out4, m4.o);
        chk({tag, ".m4.cf"}, cf4, m4.cf);
        chk({tag, ".m4.halted"}, h4, m4.h);
        chk({tag, ".m4.retired"}, ret4, m4.ret);
        chk({tag, ".m8.pc"}, pc8, m8.pc);
        chk({tag, ".m8.out"}, out8, m8.o);
        chk({tag, ".m8.cf"}, cf8, m8.cf);
        chk({tag, ".m8.halted"}, h8, m8.h);
        chk({tag, ".m8.retired"}, ret8, m8.ret);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        m4 = mstep(m4, 4, 4, int'(instr4[7:4]), int'(instr4[3:0]),
                   int'(in4), valid4, hreq4, step4);
        m8 = mstep(m8, 8, 8, int'(instr8[11:8]), int'(instr8[7:0]),
                   int'(in8), valid8, hreq8, step8);
        #1;
        cmp_models(tag);
    endtask

    typedef struct {
        bit         w8;
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] inp;
        bit         v;
        bit         h;
        bit         s;
        logic [7:0] e_out;
        logic [7:0] e_pc;
        bit         e_cf;
        bit         e_h;
        bit         e_r;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit w8, logic [3:0] op, logic [7:0] imm,
                                logic [7:0] inp, bit v, bit h, bit s,
                                logic [7:0] e_out, logic [7:0] e_pc,
                                bit e_cf, bit e_h, bit e_r);
        vec_t r;
        r.w8 = w8; r.op = op; r.imm = imm; r.inp = inp;
        r.v = v; r.h = h; r.s = s;
        r.e_out = e_out; r.e_pc = e_pc;
        r.e_cf = e_cf; r.e_h = e_h; r.e_r = e_r;
        return r;
    endfunction

    logic [7:0] prog [16];
    bit saw_wrap_cf;

    initial begin
        // 4-bit core: carry/JNC, stall, halt/step, jumps, pc wrap
        tv.push_back(mk(0, 4'h3, 8'hF, 0, 1, 0, 0, 0,  1, 0, 0, 1));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 0, 0, 0,  2, 1, 0, 1));
        tv.push_back(mk(0, 4'hE, 8'h0, 0, 1, 0, 0, 0,  3, 0, 0, 1));
        tv.push_back(mk(0, 4'h0, 8'h2, 0, 1, 0, 0, 0,  4, 0, 0, 1));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 0, 0, 0, 0,  4, 0, 0, 0));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 0, 0, 0, 0,  4, 0, 0, 0));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 0, 0, 0, 0,  4, 0, 0, 0));
        tv.push_back(mk(0, 4'h4, 8'h0, 0, 1, 0, 0, 0,  5, 0, 0, 1));
        tv.push_back(mk(0, 4'h9, 8'h0, 0, 1, 0, 0, 2,  6, 0, 0, 1));
        tv.push_back(mk(0, 4'h2, 8'h1, 7, 1, 0, 0, 2,  7, 0, 0, 1));
        tv.push_back(mk(0, 4'h5, 8'hF, 0, 1, 0, 0, 2,  8, 1, 0, 1));
        tv.push_back(mk(0, 4'h8, 8'h0, 0, 1, 0, 0, 2,  9, 1, 0, 1));
        tv.push_back(mk(0, 4'h9, 8'h0, 0, 1, 0, 0, 1, 10, 0, 0, 1));
        tv.push_back(mk(0, 4'hB, 8'h5, 0, 1, 0, 0, 5, 11, 0, 0, 1));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 1, 0, 5, 11, 0, 1, 0));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 1, 1, 5, 12, 0, 1, 1));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 0, 0, 1, 5, 12, 0, 1, 0));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 0, 1, 5, 13, 0, 1, 1));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 1, 0, 5, 13, 0, 1, 0));
        tv.push_back(mk(0, 4'h0, 8'h1, 0, 1, 0, 0, 5, 13, 0, 0, 0));
        tv.push_back(mk(0, 4'hF, 8'h3, 0, 1, 0, 0, 5,  3, 0, 0, 1));
        tv.push_back(mk(0, 4'h0, 8'h7, 0, 1, 0, 1, 5,  4, 1, 0, 1));
        tv.push_back(mk(0, 4'hE, 8'h0, 0, 1, 0, 0, 5,  5, 0, 0, 1));
        tv.push_back(mk(0, 4'hE, 8'h9, 0, 1, 0, 0, 5,  9, 0, 0, 1));
        tv.push_back(mk(0, 4'h4, 8'h0, 0, 1, 0, 0, 5, 10, 0, 0, 1));
        tv.push_back(mk(0, 4'h1, 8'h3, 0, 1, 0, 0, 5, 11, 0, 0, 1));
        tv.push_back(mk(0, 4'h4, 8'h0, 0, 1, 0, 0, 5, 12, 0, 0, 1));
        tv.push_back(mk(0, 4'h9, 8'h0, 0, 1, 0, 0, 4, 13, 0, 0, 1));
        tv.push_back(mk(0, 4'h7, 8'hE, 0, 1, 0, 0, 4, 14, 0, 0, 1));
        tv.push_back(mk(0, 4'h9, 8'h0, 0, 1, 0, 0, 14, 15, 0, 0, 1));
        tv.push_back(mk(0, 4'h6, 8'h3, 15, 1, 0, 0, 14, 0, 1, 0, 1));
        tv.push_back(mk(0, 4'h9, 8'h0, 0, 1, 0, 0, 2,  1, 0, 0, 1));
        // 8-bit core leaving reset halted
        tv.push_back(mk(1, 4'h0, 8'h00, 0,     0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tv.push_back(mk(1, 4'h3, 8'hF0, 0,     1, 0, 0, 8'h00, 8'h01, 0, 0, 1));
        tv.push_back(mk(1, 4'h0, 8'h20, 0,     1, 0, 0, 8'h00, 8'h02, 1, 0, 1));
        tv.push_back(mk(1, 4'h8, 8'h00, 0,     1, 0, 0, 8'h00, 8'h03, 1, 0, 1));
        tv.push_back(mk(1, 4'h4, 8'h00, 0,     1, 0, 0, 8'h00, 8'h04, 0, 0, 1));
        tv.push_back(mk(1, 4'h9, 8'h00, 0,     1, 0, 0, 8'h10, 8'h05, 0, 0, 1));
        tv.push_back(mk(1, 4'hF, 8'hFF, 0,     1, 0, 0, 8'h10, 8'hFF, 0, 0, 1));
        tv.push_back(mk(1, 4'h8, 8'h00, 0,     1, 0, 0, 8'h10, 8'h00, 0, 0, 1));
        tv.push_back(mk(1, 4'h6, 8'h00, 8'hA5, 1, 0, 0, 8'h10, 8'h01, 0, 0, 1));
        tv.push_back(mk(1, 4'h9, 8'h00, 0,     1, 0, 0, 8'hA5, 8'h02, 0, 0, 1));
        tv.push_back(mk(1, 4'hE, 8'h40, 0,     1, 0, 0, 8'hA5, 8'h40, 0, 0, 1));
        tv.push_back(mk(1, 4'h0, 8'hFF, 0,     1, 0, 0, 8'hA5, 8'h41, 1, 0, 1));
        tv.push_back(mk(1, 4'h0, 8'h01, 0,     1, 1, 0, 8'hA5, 8'h41, 1, 1, 0));
        tv.push_back(mk(1, 4'hC, 8'h00, 0,     1, 1, 1, 8'hA5, 8'h42, 1, 1, 1));

        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h40;
        prog[1] = 8'h90;
        prog[2] = 8'h01;
        prog[3] = 8'hE0;
        prog[4] = 8'hF4;

        m4 = mreset(1'b0);
        m8 = mreset(1'b1);
        #12;
        chk("reset.m8.halted", h8, 1);
        chk("reset.m4.halted", h4, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tv[i]) begin
            if (tv[i].w8) begin
                instr8 = {tv[i].op, tv[i].imm};
                in8 = tv[i].inp;
                valid8 = tv[i].v; hreq8 = tv[i].h; step8 = tv[i].s;
                valid4 = 0; hreq4 = 0; step4 = 0;
            end else begin
                instr4 = {tv[i].op, tv[i].imm[3:0]};
                in4 = tv[i].inp[3:0];
                valid4 = tv[i].v; hreq4 = tv[i].h; step4 = tv[i].s;
                valid8 = 0; hreq8 = 1; step8 = 0;
            end
            tick($sformatf("vec%0d", i));
            if (tv[i].w8) begin
                chk($sformatf("vec%0d.out", i), out8, tv[i].e_out);
                chk($sformatf("vec%0d.pc", i), pc8, tv[i].e_pc);
                chk($sformatf("vec%0d.cf", i), cf8, tv[i].e_cf);
                chk($sformatf("vec%0d.halted", i), h8, tv[i].e_h);
                chk($sformatf("vec%0d.retired", i), ret8, tv[i].e_r);
            end else begin
                chk($sformatf("vec%0d.out", i), out4, tv[i].e_out);
                chk($sformatf("vec%0d.pc", i), pc4, tv[i].e_pc);
                chk($sformatf("vec%0d.cf", i), cf4, tv[i].e_cf);
                chk($sformatf("vec%0d.halted", i), h4, tv[i].e_h);
                chk($sformatf("vec%0d.retired", i), ret8 & 1'b0 | ret4, tv[i].e_r);
            end
        end

        // asynchronous reset in the middle of a cycle with live state
        #3;
        rst = 1'b1;
        m4 = mreset(1'b0);
        m8 = mreset(1'b1);
        #1;
        chk("midrst.pc4", pc4, 0);
        chk("midrst.out4", out4, 0);
        chk("midrst.cf4", cf4, 0);
        chk("midrst.ret4", ret4, 0);
        chk("midrst.h4", h4, 0);
        chk("midrst.pc8", pc8, 0);
        chk("midrst.out8", out8, 0);
        chk("midrst.cf8", cf8, 0);
        chk("midrst.ret8", ret8, 0);
        chk("midrst.h8", h8, 1);
        valid4 = 0; hreq4 = 0; step4 = 0;
        valid8 = 0; hreq8 = 0; step8 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // counter loop: out_port walks 0..15, ADD wraps with carry, JNC falls out
        saw_wrap_cf = 0;
        for (int i = 0; i < 70; i++) begin
            instr4 = prog[m4.pc];
            valid4 = 1;
            tick($sformatf("loop%0d", i));
            if (instr4 == 8'h01 && cf4) saw_wrap_cf = 1;
        end
        chk("loop.out", out4, 15);
        chk("loop.pc", pc4, 4);
        chk("loop.wrap_cf", saw_wrap_cf, 1);

        for (int i = 0; i < 500; i++) begin
            instr4 = 8'($urandom);
            in4 = 4'($urandom);
            valid4 = ($urandom % 8) != 0;
            hreq4 = ($urandom % 10) == 0;
            step4 = ($urandom % 3) == 0;
            instr8 = 12'($urandom);
            in8 = 8'($urandom);
            valid8 = ($urandom % 8) != 0;
            hreq8 = ($urandom % 10) == 0;
            step8 = ($urandom % 3) == 0;
            tick($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
